// File: rtl/data_mem_ctrl.sv
// Data memory controller: a fixed-latency word memory behind a three-state
// IDLE/WAIT/RESP handshake. The CPU is held by stall_o while an access is
// in flight, and done_o pulses for one cycle when the access completes.
module data_mem_ctrl #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] word_q, word_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   rdata_q;
    logic          misalign_q;
    logic [31:0]   mem_q [DEPTH];

    logic req, aligned, commit, set_misalign;

    // Address bits above the word index are ignored, so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:AW+2];

    assign req     = MemRead_i | MemWrite_i;
    assign aligned = (addr_i[1:0] == 2'b00);

    // Next-state, request capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        is_wr_d      = is_wr_q;
        commit       = 1'b0;
        set_misalign = 1'b0;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && aligned) begin
                    stall_o = 1'b1;
                    state_d = StWait;
                    cnt_d   = 3'(LATENCY - 1);
                    word_d  = addr_i[AW+1:2];
                    wdata_d = data_i;
                    // Simultaneous read and write is treated as a write.
                    is_wr_d = MemWrite_i;
                end else if (req) begin
                    set_misalign = 1'b1;
                end
            end
            StWait: begin
                stall_o = 1'b1;
                if (cnt_q == 3'd0) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                // Requests here are ignored: the CPU advances on this edge.
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Combinational stall must not leak a request through while in reset.
        if (rst_i) begin
            stall_o = 1'b0;
        end
    end

    // Control state and latched request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            word_q  <= '0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
        end
    end

    // Memory array; a write only commits on the edge leaving WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (commit && is_wr_q) begin
            mem_q[word_q] <= wdata_q;
        end
    end

    // Load data register; holds the most recent read result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 32'd0;
        end else if (commit && !is_wr_q) begin
            rdata_q <= mem_q[word_q];
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else if (set_misalign) begin
            misalign_q <= 1'b1;
        end
    end

    assign data_o     = rdata_q;
    assign misalign_o = misalign_q;

endmodule
